// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package serial_to_parallel_rx_pkg;

  // Receiver frame state
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Fill-order encodings for the LSB_FIRST parameter
  localparam int unsigned LSB_FIRST_OFF = 0;
  localparam int unsigned LSB_FIRST_ON  = 1;

  // Bit-count register width able to hold 0..width
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_to_parallel_rx_out_reg.sv
// Output holding register with valid/ready handshake and sticky overrun.
module s2p_out_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;

  // Load a completed word when the slot is free or being drained; otherwise drop it and flag overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_load) begin
      if (!r_valid || i_ready) begin
        r_dout  <= i_word;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_dout    = r_dout;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial frame receiver: assembles WIDTH-bit words from a qualified bit stream.
module serial_to_parallel_rx
  import serial_to_parallel_rx_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_din,
  input  logic             s_valid,
  input  logic             s_start,
  output logic [WIDTH-1:0] p_dout,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_busy;

  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_cap;
  logic             w_last;

  // Next shift-register value with the incoming bit inserted at the fill end
  assign w_shreg_nxt = (LSB_FIRST == LSB_FIRST_ON)
                     ? ((r_shreg >> 1) | {s_din, {(WIDTH-1){1'b0}}})
                     : ((r_shreg << 1) | WIDTH'(s_din));

  // A bit is captured on a start, or on any qualified edge inside a frame
  assign w_cap  = s_valid && (s_start || (r_state == ST_SHIFT));

  // Capturing bit WIDTH-1 of a frame completes it (a restart never completes)
  assign w_last = s_valid && !s_start && (r_state == ST_SHIFT) &&
                  (r_cnt == CW'(WIDTH - 1));

  // Frame FSM: start/restart, bit counting, completion back to idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_busy  <= 1'b0;
    end else begin
      if (w_cap) begin
        r_shreg <= w_shreg_nxt;
      end
      if (s_valid && s_start) begin
        r_state <= ST_SHIFT;
        r_cnt   <= CW'(1);
        r_busy  <= 1'b1;
      end else if (w_last) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else if (s_valid && (r_state == ST_SHIFT)) begin
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  s2p_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_last),
    .i_word    (w_shreg_nxt),
    .i_ready   (p_ready),
    .o_dout    (p_dout),
    .o_valid   (p_valid),
    .o_overrun (overrun)
  );

  assign busy = r_busy;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench: MSB-first and LSB-first receivers against a queue-based frame model.
module tb_serial_to_parallel_rx;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_din;
  logic         s_valid;
  logic         s_start;
  logic         p_ready;
  logic [W-1:0] dout_m, dout_l;
  logic         valid_m, valid_l;
  logic         busy_m, busy_l;
  logic         ovr_m, ovr_l;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit           mq[$];
  bit           m_in;
  bit           m_v;
  bit           m_ov;
  logic [W-1:0] m_dm;
  logic [W-1:0] m_dl;

  always #5 clk = ~clk;

  serial_to_parallel_rx #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .s_din(s_din), .s_valid(s_valid), .s_start(s_start),
    .p_dout(dout_m), .p_valid(valid_m), .p_ready(p_ready), .busy(busy_m), .overrun(ovr_m)
  );

  serial_to_parallel_rx #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .s_din(s_din), .s_valid(s_valid), .s_start(s_start),
    .p_dout(dout_l), .p_valid(valid_l), .p_ready(p_ready), .busy(busy_l), .overrun(ovr_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the edge, then compare both receivers against it
  task automatic step();
    bit           load;
    logic [W-1:0] wm, wl;
    @(posedge clk);
    load = 1'b0;
    wm   = '0;
    wl   = '0;
    if (!rst_n) begin
      mq.delete();
      m_in = 1'b0; m_v = 1'b0; m_ov = 1'b0; m_dm = '0; m_dl = '0;
    end else begin
      if (s_valid) begin
        if (s_start) begin
          mq.delete();
          m_in = 1'b1;
        end
        if (m_in) mq.push_back(s_din);
        if (mq.size() == W) begin
          load = 1'b1;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = mq[i];
            wl[i]     = mq[i];
          end
          mq.delete();
          m_in = 1'b0;
        end
      end
      if (load) begin
        if (!m_v || p_ready) begin
          m_v = 1'b1; m_dm = wm; m_dl = wl;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_v && p_ready) begin
        m_v = 1'b0;
      end
    end
    #1;
    chk("msb_valid", 32'(valid_m), 32'(m_v));
    chk("msb_dout",  32'(dout_m),  32'(m_dm));
    chk("msb_busy",  32'(busy_m),  32'(m_in));
    chk("msb_ovr",   32'(ovr_m),   32'(m_ov));
    chk("lsb_valid", 32'(valid_l), 32'(m_v));
    chk("lsb_dout",  32'(dout_l),  32'(m_dl));
    chk("lsb_busy",  32'(busy_l),  32'(m_in));
    chk("lsb_ovr",   32'(ovr_l),   32'(m_ov));
  endtask

  // Send a frame, first bit = b[W-1], with start on the first bit and idle gaps between bits
  task automatic frame(input logic [W-1:0] b, input int gap);
    for (int i = 0; i < W; i++) begin
      s_valid = 1'b1;
      s_start = (i == 0);
      s_din   = b[W-1-i];
      step();
      s_valid = 1'b0;
      s_start = 1'b0;
      if (i < W - 1) begin
        for (int g = 0; g < gap; g++) begin
          step();
          chk("busy_gap", 32'(busy_m), 32'd1);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; s_din = 1'b0; s_valid = 1'b0; s_start = 1'b0; p_ready = 1'b1;
    m_in = 1'b0; m_v = 1'b0; m_ov = 1'b0; m_dm = '0; m_dl = '0;
    step(); step();
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_busy",  32'(busy_m),  32'd0);
    chk("rst_dout",  32'(dout_m),  32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back bits 1,1,0,1
    frame(4'b1101, 0);
    chk("b2b_valid",    32'(valid_m), 32'd1);
    chk("b2b_dout_msb", 32'(dout_m),  32'hD);
    chk("b2b_dout_lsb", 32'(dout_l),  32'hB);
    chk("b2b_ovr",      32'(ovr_m),   32'd0);
    chk("b2b_busy",     32'(busy_m),  32'd0);
    step();
    chk("b2b_drain",    32'(valid_m), 32'd0);

    // Bits 1,0,1,1 with 3-cycle gaps
    frame(4'b1011, 3);
    chk("gap_valid",    32'(valid_m), 32'd1);
    chk("gap_dout_msb", 32'(dout_m),  32'hB);
    chk("gap_dout_lsb", 32'(dout_l),  32'hD);
    chk("gap_busy",     32'(busy_m),  32'd0);
    step();

    // Stalled consumer: second word dropped, overrun sticky
    p_ready = 1'b0;
    frame(4'b1101, 0);
    frame(4'b0110, 0);
    chk("ovr_dout_msb", 32'(dout_m),  32'hD);
    chk("ovr_dout_lsb", 32'(dout_l),  32'hB);
    chk("ovr_flag",     32'(ovr_m),   32'd1);
    chk("ovr_valid",    32'(valid_m), 32'd1);
    p_ready = 1'b1;
    step();
    chk("ovr_accept",   32'(valid_m), 32'd0);
    chk("ovr_sticky",   32'(ovr_m),   32'd1);

    // Restart mid-frame
    rst_n = 1'b0; step(); rst_n = 1'b1;
    s_valid = 1'b1; s_start = 1'b1; s_din = 1'b1; step();
    s_start = 1'b0; s_din = 1'b0; step();
    s_valid = 1'b0;
    frame(4'b0111, 0);
    chk("rs_dout_msb", 32'(dout_m), 32'h7);
    chk("rs_dout_lsb", 32'(dout_l), 32'hE);
    chk("rs_ovr",      32'(ovr_m),  32'd0);
    step();

    // Reset after two bits discards the partial frame
    s_valid = 1'b1; s_start = 1'b1; s_din = 1'b1; step();
    s_start = 1'b0; s_din = 1'b1; step();
    s_valid = 1'b0; rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mr_valid", 32'(valid_m), 32'd0);
    chk("mr_busy",  32'(busy_m),  32'd0);
    chk("mr_dout",  32'(dout_m),  32'd0);
    chk("mr_ovr",   32'(ovr_m),   32'd0);
    frame(4'b1101, 0);
    chk("mr_next_msb", 32'(dout_m), 32'hD);
    chk("mr_next_lsb", 32'(dout_l), 32'hB);

    // Qualified bits without start while idle are ignored
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_start = 1'b0; s_din = 1'(i & 1);
      step();
      chk("nostart_valid", 32'(valid_m), 32'd0);
      chk("nostart_busy",  32'(busy_m),  32'd0);
    end
    s_valid = 1'b0;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      s_valid = ($urandom_range(0, 2) != 0);
      s_start = ($urandom_range(0, 7) == 0);
      s_din   = 1'($urandom_range(0, 1));
      p_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
